// File: rtl/cal_eep_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : cal_eep_spi_slave_if
//  Brief    : Four-wire SPI bundle between the EEPROM master and responder.
//  Revision : 1.0  initial release
// ============================================================================
interface cal_eep_spi_slave_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface
`default_nettype wire

// File: rtl/cal_eep_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : cal_eep_spi_slave
//  Brief    : SPI mode-0 responder emulating the 64x8 calibration EEPROM.
//  Revision : 1.0  initial release
// ============================================================================
module cal_eep_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_VAL    = 8'h00
) (
    input  wire logic                clk,
    input  wire logic                rst,
    cal_eep_spi_slave_if.slave       spi,
    output logic                     wr_pulse,
    output logic                     rd_pulse,
    output logic                     frame_err,
    output logic [5:0]               last_addr
);

    localparam logic [4:0] c_bit_max  = 5'd31;
    localparam logic [4:0] c_frame_len = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_ss_d;
    logic                   r_sclk_d;

    logic [15:0] r_rx;
    logic [15:0] r_tx;
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_rd_byte;
    logic [7:0]  r_mem [64];

    logic w_ss_s, w_sclk_s, w_mosi_s;
    logic w_ss_rise, w_sclk_rise, w_sclk_fall;
    logic w_frame_start, w_frame_end;
    logic w_shift_in, w_shift_out;
    logic w_len_ok;
    logic w_do_wr, w_do_rd, w_do_err;
    logic [5:0] w_addr;

    // Idle levels on reset keep a released reset from looking like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_d      <= 1'b1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   spi.SS_n};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            r_ss_d      <= w_ss_s;
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_ss_rise   = w_ss_s & ~r_ss_d;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame start is level-sensitive so a select arriving during COMMIT is kept.
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_shift_in    = 1'b0;
        w_shift_out   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ss_s) begin
                    w_state_nxt   = ST_SHIFT;
                    w_frame_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_COMMIT;
                    w_frame_end = 1'b1;
                end else begin
                    w_shift_in  = w_sclk_rise;
                    w_shift_out = w_sclk_fall;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Decoding on the SHIFT->COMMIT edge makes the pulses land in COMMIT.
    assign w_len_ok = (r_bit_cnt == c_frame_len);
    assign w_addr   = r_rx[13:8];
    assign w_do_err = w_frame_end & ~w_len_ok;
    assign w_do_wr  = w_frame_end & w_len_ok & (r_rx[15:14] == 2'b01);
    assign w_do_rd  = w_frame_end & w_len_ok & (r_rx[15:14] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx      <= 16'h0000;
            r_tx      <= 16'h0000;
            r_bit_cnt <= 5'd0;
            r_rd_byte <= 8'h00;
            wr_pulse  <= 1'b0;
            rd_pulse  <= 1'b0;
            frame_err <= 1'b0;
            last_addr <= 6'd0;
            for (int i = 0; i < 64; i++) begin
                r_mem[i] <= FILL_VAL;
            end
        end else begin
            wr_pulse  <= w_do_wr;
            rd_pulse  <= w_do_rd;
            frame_err <= w_do_err;

            if (w_frame_start) begin
                r_tx      <= {8'h00, r_rd_byte};
                r_rx      <= 16'h0000;
                r_bit_cnt <= 5'd0;
            end

            if (w_shift_in) begin
                r_rx      <= {r_rx[14:0], w_mosi_s};
                r_bit_cnt <= (r_bit_cnt == c_bit_max) ? c_bit_max : r_bit_cnt + 5'd1;
            end

            if (w_shift_out) begin
                r_tx <= {r_tx[14:0], 1'b0};
            end

            if (w_do_wr) begin
                r_mem[w_addr] <= r_rx[7:0];
                last_addr     <= w_addr;
            end

            if (w_do_rd) begin
                r_rd_byte <= r_mem[w_addr];
                last_addr <= w_addr;
            end
        end
    end

    assign spi.MISO = (r_state == ST_SHIFT) & r_tx[15];

endmodule
`default_nettype wire

// File: tb/tb_cal_eep_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cal_eep_spi_slave
//  Brief    : Self-checking bench for cal_eep_spi_slave against an array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cal_eep_spi_slave;

    localparam logic [7:0] c_fill = 8'h00;
    localparam int         c_half = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_pulse, rd_pulse, frame_err;
    logic [5:0] last_addr;

    cal_eep_spi_slave_if spi ();

    cal_eep_spi_slave #(
        .SYNC_STAGES (2),
        .FILL_VAL    (c_fill)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .wr_pulse  (wr_pulse),
        .rd_pulse  (rd_pulse),
        .frame_err (frame_err),
        .last_addr (last_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mon_wr = 0, mon_rd = 0, mon_err = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0;

    logic [7:0] m_mem [64];
    logic [7:0] m_rd;
    logic [5:0] m_last;

    always @(negedge clk) begin
        if (wr_pulse)  mon_wr++;
        if (rd_pulse)  mon_rd++;
        if (frame_err) mon_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = c_fill;
        m_rd   = 8'h00;
        m_last = 6'd0;
    endtask

    // Applies the frame rules to the model and drives the SPI wires.
    task automatic do_frame(input logic [15:0] word, input int nbits, input int gap);
        logic [15:0] cap;
        logic [15:0] exp_miso;
        logic [5:0]  a;
        cap      = 16'h0000;
        exp_miso = {8'h00, m_rd} >> (16 - nbits);
        a        = word[13:8];
        if (nbits != 16) begin
            exp_err++;
        end else if (word[15:14] == 2'b01) begin
            m_mem[a] = word[7:0];
            m_last   = a;
            exp_wr++;
        end else if (word[15:14] == 2'b00) begin
            m_rd   = m_mem[a];
            m_last = a;
            exp_rd++;
        end
        spi.SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi.MOSI = word[15-i];
            wait_clk(c_half);
            cap = {cap[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            wait_clk(c_half);
            spi.SCLK = 1'b0;
        end
        wait_clk(c_half);
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        wait_clk(gap);
        check_val("miso_word", 32'(cap), 32'(exp_miso));
    endtask

    task automatic check_status(input string tag);
        wait_clk(8);
        check_val({tag, "_wr_cnt"},  mon_wr,  exp_wr);
        check_val({tag, "_rd_cnt"},  mon_rd,  exp_rd);
        check_val({tag, "_err_cnt"}, mon_err, exp_err);
        check_val({tag, "_last"},    32'(last_addr), 32'(m_last));
        check_val({tag, "_miso_idle"}, 32'(spi.MISO), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        int         sel;
        int         nb;
        int         gap;
        logic [15:0] w;

        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        model_reset();
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check_val("rst_last",  32'(last_addr), 32'd0);
        check_val("rst_wr",    32'(wr_pulse),  32'd0);
        check_val("rst_rd",    32'(rd_pulse),  32'd0);
        check_val("rst_err",   32'(frame_err), 32'd0);
        check_val("rst_miso",  32'(spi.MISO),  32'd0);

        // Read of a filled location, then a dummy response frame.
        do_frame(16'h0005, 16, 10);
        do_frame(16'hBCBC, 16, 10);
        check_status("rd5");

        do_frame(16'h4A3C, 16, 10);
        check_status("wr0a");
        do_frame(16'h000A, 16, 10);
        do_frame(16'hBCBC, 16, 10);
        check_status("rd0a");

        // Short frame must be discarded without touching memory.
        do_frame(16'h4AFF, 12, 10);
        check_status("short");
        do_frame(16'h000A, 16, 10);
        do_frame(16'hBCBC, 16, 10);
        check_status("rd0a_again");

        do_frame(16'hC0FF, 16, 10);
        check_status("ignore");
        do_frame(16'h0000, 16, 10);
        do_frame(16'hBCBC, 16, 10);
        check_status("rd00");

        // Back-to-back frames with a two-clock deselect gap.
        do_frame(16'h405A, 16, 2);
        do_frame(16'h7FC3, 16, 2);
        do_frame(16'h0000, 16, 2);
        do_frame(16'h003F, 16, 2);
        do_frame(16'hBCBC, 16, 10);
        check_status("b2b");

        // Reset in the middle of a write to 0x3F.
        w = 16'h7F55;
        spi.SS_n = 1'b0;
        for (int i = 0; i < 9; i++) begin
            spi.MOSI = w[15-i];
            wait_clk(c_half);
            spi.SCLK = 1'b1;
            wait_clk(c_half);
            spi.SCLK = 1'b0;
        end
        rst      = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b0;
        spi.MOSI = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        model_reset();
        check_val("mid_rst_last", 32'(last_addr), 32'd0);
        check_val("mid_rst_miso", 32'(spi.MISO),  32'd0);
        check_status("mid_rst");
        do_frame(16'h003F, 16, 10);
        do_frame(16'hBCBC, 16, 10);
        check_status("rd3f");

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 9);
            gap = $urandom_range(2, 6);
            nb  = 16;
            w   = 16'($urandom);
            if (sel < 4) begin
                w[15:14] = 2'b01;
            end else if (sel < 7) begin
                w[15:14] = 2'b00;
            end else if (sel == 7) begin
                w[15] = 1'b1;
            end else begin
                nb = $urandom_range(1, 15);
            end
            do_frame(w, nb, gap);
            if ((k % 5) == 4) check_status("rand");
        end
        do_frame(16'hBCBC, 16, 10);
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cal_eep_spi_slave.md
Name: cal_eep_spi_slave

Overview:
- SPI responder model of the 64x8 calibration EEPROM, the far end of the command processor's EEP_WRT / EEP_RD SPI traffic.
- Receives 16-bit mode-0 frames on the EEPROM slave select, decodes write/read commands, and updates internal storage.
- Returns read data in the following frame.
- Used in the full-chip testbench and in FPGA loopback builds in place of the physical EEPROM.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on SS_n, SCLK and MOSI (minimum 2).
- FILL_VAL, 8'h00, value written to every memory location on reset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low, asynchronous to clk.
- SCLK  input  1  SPI clock, asynchronous to clk; idles low (mode 0).
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- wr_pulse  output  1  one-clk pulse when a write commits.
- rd_pulse  output  1  one-clk pulse when a read address is latched.
- frame_err  output  1  one-clk pulse when a frame is discarded.
- last_addr  output  6  address of the most recent committed command.

Behaviour:
- Synchronization:
  - SS_n, SCLK and MOSI pass through SYNC_STAGES flops.
  - Edge detection uses the last synchronized stage against one extra delayed copy.
  - Requirement: SCLK high and low phases each ≥ 4 clk.
- Reset (rst=1 at a clk edge):
  - All 64 memory locations are set to FILL_VAL.
  - rd_byte = 8'h00; tx_shift = 16'h0000; bit_cnt = 0; state = IDLE.
  - MISO = 0; wr_pulse = rd_pulse = frame_err = 0; last_addr = 0.
  - A reset asserted mid-frame abandons the frame. No commit and no pulse occur.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on a detected SS_n falling edge, load tx_shift = {8'h00, rd_byte}, clear bit_cnt and rx_shift, go to SHIFT.
  - SHIFT:
    - On an SCLK rising edge: rx_shift = {rx_shift[14:0], MOSI_sync}; bit_cnt saturates at 31.
    - On an SCLK falling edge: tx_shift <<= 1.
    - On an SS_n rising edge: go to COMMIT.
  - COMMIT (one cycle), then IDLE:
    - If bit_cnt != 16: frame_err = 1; no memory or rd_byte change.
    - Else if rx[15:14] = 2'b01 (write): mem[rx[13:8]] <= rx[7:0]; wr_pulse = 1; last_addr = rx[13:8].
    - Else if rx[15:14] = 2'b00 (read): rd_byte <= mem[rx[13:8]]; rd_pulse = 1; last_addr = rx[13:8].
    - Else (2'b1x): frame ignored; no pulse, no state change beyond returning to IDLE.
- MISO:
  - MISO = tx_shift[15] while state = SHIFT, else 0.
  - Bit 15 is valid before the first SCLK rise.
  - The read response therefore appears in bits [7:0] of the frame after the read command.
  - Any frame type, including a dummy 16'hBCBC, serves as the response frame.
- Simultaneous events:
  - An SCLK edge detected in the same cycle as the SS_n rise is ignored.
  - An SS_n falling edge during COMMIT is taken after COMMIT. The IDLE edge check uses the level, so it is not lost: when SS_n_sync = 0 in IDLE, IDLE treats it as a frame start.
  - A write followed by a read of the same address returns the newly written value.
- Pulses are registered and high for exactly one clk, in the COMMIT cycle.

Test Plan:
- Reset, then a 16-bit frame 16'h0005 (read addr 5) followed by 16'hBCBC -> rd_pulse once, last_addr=5, MISO bits [7:0] of the 2nd frame = FILL_VAL (8'h00).
- Frame 16'h4A3C (write addr 0x0A data 0x3C) -> wr_pulse once, last_addr=0x0A. Then read 16'h000A plus dummy frame -> MISO low byte 8'h3C, high byte 8'h00.
- Frame of only 12 SCLKs, then SS_n high -> frame_err pulse; a subsequent read of 0x0A still returns 8'h3C.
- Frame 16'hC0FF (cmd 2'b11) -> no wr_pulse, rd_pulse or frame_err; memory unchanged.
- Reset asserted after bit 9 of a write frame to addr 0x3F -> all outputs at reset values; a later read of 0x3F returns 8'h00.
- Back-to-back writes to addr 0 and addr 63 (SS_n high for 2 clk between frames), then reads -> 8'hxx values match and no frame lost.
